mips32_prefetch_queue: RTL and testbench
========================================

Name: mips32_prefetch_queue

Overview:
Instruction-fetch front end for the MIPS32 pipeline. It issues word-addressed reads to instruction memory and buffers the returned instruction words, each paired with its NPC (PC+1), in a small in-order queue. The queue feeds the IF/ID latch through a valid/ready interface. A taken branch (redirect) flushes the queue and discards every response already in flight.

Parameters:
DEPTH, 4, queue entries; also the maximum of (queued + in-flight) requests; power of two, ≥2
ADDR_W, 10, instruction word-address width (1024-word memory)
DATA_W, 32, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  single clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word address of the request
mem_rsp_valid  in  1  read data valid; responses return in request order, latency ≥1 cycle
mem_rsp_data  in  DATA_W  instruction word
if_valid  out  1  head entry available
if_ready  in  1  IF/ID consumes head
if_ir  out  DATA_W  head instruction
if_npc  out  ADDR_W  head NPC (instruction address + 1)
redirect_valid  in  1  branch taken; flush and refetch
redirect_pc  in  ADDR_W  branch target word address
halt  in  1  stop issuing new requests

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc and rsp_pc are set to RESET_PC; count, inflight and drop_cnt are set to 0.
  - if_valid=0, mem_req_valid=0. if_ir and if_npc read 0 while empty.
- Issue:
  - mem_req_valid = !rst && !halt && !redirect_valid && (count + inflight) < DEPTH; combinational from registered state.
  - mem_addr = fetch_pc.
  - When valid&&ready: fetch_pc ← fetch_pc+1, wrapping mod 2^ADDR_W; inflight increments.
- Response:
  - Each mem_rsp_valid decrements inflight.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise the response is pushed as {mem_rsp_data, rsp_pc+1} and rsp_pc increments (wrapping).
  - A push can never overflow, because of the issue rule.
- Output:
  - if_valid = (count≠0); if_ir and if_npc come from the head entry, driven combinationally from registers.
  - Pop on if_valid&&if_ready.
  - A push and a pop in the same cycle leave count unchanged; this is legal at full and at empty (empty: push lands, no pop).
- Latency: a response accepted at posedge N gives if_valid=1 from N+1 (registered queue, no bypass).
- Redirect (redirect_valid=1 at posedge):
  - The queue is emptied (count←0, pointers reset) and any pop in that cycle is ignored.
  - fetch_pc ← redirect_pc and rsp_pc ← redirect_pc.
  - A response arriving in the same cycle is discarded.
  - drop_cnt ← inflight − (mem_rsp_valid?1:0), i.e. all still-outstanding requests.
  - No request is issued in the redirect cycle. The first request to redirect_pc goes out the next cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Halt:
  - Only request issue is gated. In-flight responses are still accepted and the queue still drains.
  - Redirect overrides halt for the pc update, but issue stays blocked while halt=1.
- Protocol error: mem_rsp_valid with inflight==0 is ignored; counters do not underflow.
- Widths:
  - Counters are clog2(DEPTH)+1 bits.
  - NPC arithmetic is ADDR_W bits, modulo wrap (address 1023 → NPC 0).
- Reset mid-operation: outstanding memory responses after reset are treated as protocol errors by the bench (memory is reset alongside).

Decomposition:
- Shared package mips32_pkg:
  - opcode constants (ADD…BEQZ, HLT);
  - instruction-type codes (RR_ALU…HALT);
  - ADDR_W/DATA_W defaults;
  - typedef for the queue entry {ir, npc}.
- One sub-module, mips32_sync_fifo: DEPTH×(DATA_W+ADDR_W) storage, push/pop/flush, count, head output.
- Issue, in-flight and drop accounting stay in the top module.

Test Plan:
- Mem[0..5]=0x28010005.., zero-latency-1 memory, if_ready=1 → if_ir streams Mem[0],Mem[1]… with if_npc 1,2,3…; one instruction per cycle after a 2-cycle fill.
- if_ready=0 for 10 cycles → exactly 4 requests issued, count=4, mem_req_valid=0; release → 4 entries in order, then issue resumes at addr 4.
- Memory latency 3 with 3 requests in flight, redirect_pc=0x20 → 3 stale responses dropped, the next if_ir is Mem[0x20] with if_npc=0x21.
- Redirect in the same cycle as a response and a pop at count=2 → queue empty next cycle, drop_cnt=inflight−1, no stale word reaches if_ir.
- halt=1 with 2 queued and 1 in flight → no new mem_req_valid; 3 entries delivered, then if_valid=0 indefinitely.
- Start from RESET_PC=1022 → NPCs 1023, 0, 1 (wrap); rst asserted mid-stream → next cycle if_valid=0 and mem_addr=RESET_PC.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes, default widths
// and the fetch-queue entry layout.
package mips32_pkg;

  localparam int MIPS_ADDR_W = 10;
  localparam int MIPS_DATA_W = 32;

  typedef enum logic [5:0] {
    ADD   = 6'b000000,
    SUB   = 6'b000001,
    AND   = 6'b000010,
    OR    = 6'b000011,
    SLT   = 6'b000100,
    MUL   = 6'b000101,
    LW    = 6'b001000,
    SW    = 6'b001001,
    ADDI  = 6'b001010,
    SUBI  = 6'b001011,
    SLTI  = 6'b001100,
    BNEQZ = 6'b001101,
    BEQZ  = 6'b001110,
    HLT   = 6'b111111
  } opcode_t;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } itype_t;

  typedef struct packed {
    logic [MIPS_DATA_W-1:0] ir;
    logic [MIPS_ADDR_W-1:0] npc;
  } fetch_entry_t;

  // Undefined opcodes fall into the halt class so decode never stalls on junk.
  function automatic itype_t opcode_class(input logic [5:0] op);
    itype_t t;
    case (op)
      ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
      ADDI, SUBI, SLTI:            t = RM_ALU;
      LW:                          t = LOAD;
      SW:                          t = STORE;
      BNEQZ, BEQZ:                 t = BRANCH;
      default:                     t = HALT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// In-order synchronous FIFO with flush; head reads zero while empty.
module mips32_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  // A push at full is only accepted when a pop frees the slot in the same cycle.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != ($clog2(DEPTH)+1)'(DEPTH)) || pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !flush) mem[wr_ptr] <= wdata;
  end

  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

endmodule

// File: rtl/mips32_prefetch_queue.sv
// Instruction-fetch front end: issues word reads, queues {ir, npc} pairs for
// IF/ID and discards stale in-flight responses after a taken branch.
module mips32_prefetch_queue
  import mips32_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = MIPS_ADDR_W,
  parameter int                DATA_W   = MIPS_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_ir,
  output logic [ADDR_W-1:0] if_npc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        rsp_pc;
  logic [ADDR_W-1:0]        rsp_npc;
  logic [CW-1:0]            count;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            drop_cnt;
  logic [CW:0]              occupancy;
  logic                     issue;
  logic                     rsp_live;
  logic                     push;
  logic                     pop;
  logic [DATA_W+ADDR_W-1:0] head;

  // Queued plus outstanding requests never exceed DEPTH, so a push always fits.
  always_comb begin
    occupancy     = {1'b0, count} + {1'b0, inflight};
    mem_req_valid = !rst && !halt && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    mem_addr      = fetch_pc;
    issue         = mem_req_valid && mem_req_ready;
    rsp_live      = mem_rsp_valid && (inflight != '0);
    push          = rsp_live && (drop_cnt == '0) && !redirect_valid;
    if_valid      = (count != '0);
    pop           = if_valid && if_ready && !redirect_valid;
    rsp_npc       = rsp_pc + 1'b1;
    if_ir         = head[DATA_W+ADDR_W-1:ADDR_W];
    if_npc        = head[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(rsp_live);
      if (redirect_valid) begin
        // Every request still outstanding after this edge belongs to the old path.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= inflight - CW'(rsp_live);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 1'b1;
        if (push)  rsp_pc   <= rsp_npc;
        if (rsp_live && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  mips32_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({mem_rsp_data, rsp_npc}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_mips32_prefetch_queue.sv
// Bench for mips32_prefetch_queue: directed table, corner-case sequences and
// randomized traffic against an epoch-tagged queue model of the fetch unit.
module tb_mips32_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_ir;
  logic [AW-1:0] if_npc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;

  always #5 clk = ~clk;

  mips32_prefetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (10'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_npc         (if_npc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  typedef struct {
    logic [DW-1:0] ir;
    logic [AW-1:0] npc;
  } ent_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    int            ep;
  } req_t;

  typedef struct {
    bit            rdy;
    bit            req;
    logic [AW-1:0] addr;
    bit            ifv;
    logic [AW-1:0] npc;
  } vec_t;

  ent_t          exp_q[$];
  req_t          pend[$];
  vec_t          tbl[10];
  int            n_vec, n_err, cyc, epoch, lat, issued, delivered, got;
  bit            rand_mode, inject, rsp_from_mem, e_req, s_req;
  logic [AW-1:0] m_fetch, m_rsp, s_addr, last_issue_addr, tnpc;
  logic [AW-1:0] npcs[3];

  function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
    return 32'h28010005 + (32'(a) << 16) + 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Drive the memory response for this cycle and let the DUT settle.
  task automatic settle();
    rsp_from_mem = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      rsp_from_mem  = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memword(pend[0].addr);
    end else if (inject && pend.size() == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEADBEEF;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic check_model();
    e_req = !rst && !halt && !redirect_valid && ((exp_q.size() + pend.size()) < DEPTH);
    chk("mem_req_valid", mem_req_valid, e_req);
    chk("mem_addr", mem_addr, m_fetch);
    chk("if_valid", if_valid, exp_q.size() != 0);
    chk("if_ir", if_ir, (exp_q.size() != 0) ? exp_q[0].ir : '0);
    chk("if_npc", if_npc, (exp_q.size() != 0) ? exp_q[0].npc : '0);
    s_req  = mem_req_valid;
    s_addr = mem_addr;
  endtask

  task automatic advance();
    req_t p;
    bit   pop;
    p = '{addr: '0, due: 0, ep: -1};
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pend.delete();
      m_fetch = '0;
      m_rsp   = '0;
      epoch++;
    end else begin
      if (rsp_from_mem) p = pend.pop_front();
      pop = (exp_q.size() != 0) && if_ready && !redirect_valid;
      if (pop) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        m_fetch = redirect_pc;
        m_rsp   = redirect_pc;
      end else if (rsp_from_mem && p.ep == epoch) begin
        exp_q.push_back('{memword(m_rsp), m_rsp + 10'd1});
        m_rsp = m_rsp + 10'd1;
      end
      if (s_req && mem_req_ready) begin
        pend.push_back('{s_addr, cyc + (rand_mode ? int'($urandom_range(1, 4)) : lat), epoch});
        issued++;
        last_issue_addr = s_addr;
      end
      if (e_req && mem_req_ready) m_fetch = m_fetch + 10'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    check_model();
    advance();
  endtask

  task automatic do_reset();
    halt           = 1'b0;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    rand_mode      = 1'b0;
    inject         = 1'b0;
    lat            = 1;
    rst            = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 10'd0, 1'b0, 10'd0};
    tbl[1] = '{1'b1, 1'b1, 10'd1, 1'b0, 10'd0};
    tbl[2] = '{1'b1, 1'b1, 10'd2, 1'b1, 10'd1};
    tbl[3] = '{1'b1, 1'b1, 10'd3, 1'b1, 10'd2};
    tbl[4] = '{1'b1, 1'b1, 10'd4, 1'b1, 10'd3};
    tbl[5] = '{1'b1, 1'b1, 10'd5, 1'b1, 10'd4};
    tbl[6] = '{1'b0, 1'b1, 10'd6, 1'b1, 10'd5};
    tbl[7] = '{1'b0, 1'b1, 10'd7, 1'b1, 10'd5};
    tbl[8] = '{1'b0, 1'b0, 10'd8, 1'b1, 10'd5};
    tbl[9] = '{1'b0, 1'b0, 10'd8, 1'b1, 10'd5};

    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; lat = 1;
    issued = 0; delivered = 0;
    rand_mode = 1'b0; inject = 1'b0;
    rst = 1'b1; halt = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    m_fetch = '0; m_rsp = '0; last_issue_addr = '0;

    // Bring registers out of X before any comparison.
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Streaming from reset, then backpressure filling the queue.
    for (int i = 0; i < 10; i++) begin
      if_ready = tbl[i].rdy;
      settle();
      tnpc = tbl[i].npc - 10'd1;
      chk("tbl_req_valid", mem_req_valid, tbl[i].req);
      chk("tbl_addr", mem_addr, tbl[i].addr);
      chk("tbl_if_valid", if_valid, tbl[i].ifv);
      chk("tbl_if_npc", if_npc, tbl[i].ifv ? tbl[i].npc : '0);
      chk("tbl_if_ir", if_ir, tbl[i].ifv ? memword(tnpc) : '0);
      check_model();
      advance();
    end
    if_ready = 1'b1;
    repeat (8) step();

    // Backpressure: exactly DEPTH requests, then resume at address DEPTH.
    do_reset();
    if_ready = 1'b0;
    issued = 0;
    repeat (10) step();
    chk("bp_issued", issued, 4);
    chk("bp_req_blocked", mem_req_valid, 0);
    if_ready = 1'b1;
    for (int n = 0; n < 20 && issued < 5; n++) step();
    chk("bp_resume_addr", last_issue_addr, 4);
    repeat (4) step();

    // Redirect with three requests outstanding at latency 3.
    do_reset();
    lat = 3;
    if_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 10'h020;
    step();
    redirect_valid = 1'b0;
    got = 0;
    for (int n = 0; n < 30 && !if_valid; n++) begin
      step();
      got++;
    end
    chk("redir_timeout", got < 30, 1);
    chk("redir_ir", if_ir, memword(10'h020));
    chk("redir_npc", if_npc, 10'h021);

    // Redirect coinciding with a response and a pop at count 2.
    do_reset();
    if_ready = 1'b0;
    repeat (3) step();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h040;
    step();
    redirect_valid = 1'b0;
    chk("rr_empty", if_valid, 0);
    chk("rr_addr", mem_addr, 10'h040);
    got = 0;
    for (int n = 0; n < 30 && !if_valid; n++) begin
      step();
      got++;
    end
    chk("rr_timeout", got < 30, 1);
    chk("rr_ir", if_ir, memword(10'h040));
    chk("rr_npc", if_npc, 10'h041);

    // Halt with two queued and one in flight: drains three, issues nothing.
    do_reset();
    if_ready = 1'b0;
    repeat (3) step();
    halt = 1'b1;
    step();
    if_ready = 1'b1;
    issued = 0;
    delivered = 0;
    repeat (12) step();
    chk("halt_delivered", delivered, 3);
    chk("halt_issued", issued, 0);
    chk("halt_if_valid", if_valid, 0);
    halt = 1'b0;

    // Address wrap: NPCs 1023, 0, 1.
    do_reset();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd1022;
    step();
    redirect_valid = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && got < 3; n++) begin
      if (if_valid) begin
        npcs[got] = if_npc;
        got++;
      end
      step();
    end
    chk("wrap_count", got, 3);
    chk("wrap_npc0", npcs[0], 10'd1023);
    chk("wrap_npc1", npcs[1], 10'd0);
    chk("wrap_npc2", npcs[2], 10'd1);

    // Reset in the middle of a stream.
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_addr", mem_addr, 10'd0);

    // Response with nothing outstanding is ignored.
    halt = 1'b1;
    inject = 1'b1;
    repeat (3) step();
    inject = 1'b0;
    chk("proto_if_valid", if_valid, 0);
    halt = 1'b0;
    repeat (6) step();

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      mem_req_ready  = ($urandom_range(0, 4) != 0);
      halt           = ($urandom_range(0, 29) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = AW'($urandom);
      rst            = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
